// File: rtl/cpc_ram_pkg.sv
// rtl/cpc_ram_pkg.sv - shared types and constants for the CPC RAM config capture
package cpc_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_WAIT_END = 2'd2
    } qual_state_e;

    localparam logic [1:0] CFG_TAG    = 2'b11;
    localparam int         RAMBLOCK_W = 8;

    function automatic logic [RAMBLOCK_W-1:0] cfg_word(input logic       a10,
                                                       input logic       a9,
                                                       input logic [5:0] d_lo);
        return {a10, a9, d_lo};
    endfunction

endpackage

// File: rtl/cpc_iowr_qual.sv
// rtl/cpc_iowr_qual.sv - decodes and debounces I/O writes to &7Fxx, emits one cap per I/O cycle
module cpc_iowr_qual
    import cpc_ram_pkg::*;
#(
    parameter int QUAL_SAMPLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iorq_b,
    input  logic       wr_b,
    input  logic       m1_b,
    input  logic       adr15,
    input  logic [1:0] data_tag,
    output logic       cap
);

    localparam logic [1:0] QS = 2'(QUAL_SAMPLES);

    qual_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  cnt_inc;
    logic        q;

    // M1 low with IORQ low is an interrupt acknowledge, never a port write
    assign q       = ~iorq_b & ~wr_b & m1_b & ~adr15 & (data_tag == CFG_TAG);
    assign cnt_inc = cnt_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (q) begin
                    cnt_d = 2'd1;
                    if (QS == 2'd1) begin
                        cap     = 1'b1;
                        state_d = ST_WAIT_END;
                    end else begin
                        state_d = ST_ARM;
                    end
                end else begin
                    cnt_d = 2'd0;
                end
            end
            ST_ARM: begin
                if (q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == QS) begin
                        cap     = 1'b1;
                        state_d = ST_WAIT_END;
                    end
                end else begin
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_END: begin
                // hold off until IORQ ends so a long write captures only once
                if (iorq_b) begin
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 2'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cpc_ram_cfg_capture.sv
// rtl/cpc_ram_cfg_capture.sv - single-clock capture and idle-time commit of the RAM bank-select register
module cpc_ram_cfg_capture
    import cpc_ram_pkg::*;
#(
    parameter int QUAL_SAMPLES    = 2,
    parameter bit APPLY_IDLE_ONLY = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  iorq_b,
    input  logic                  wr_b,
    input  logic                  m1_b,
    input  logic                  mreq_b,
    input  logic                  adr15,
    input  logic                  adr10,
    input  logic                  adr9,
    input  logic [7:0]            data,
    output logic [RAMBLOCK_W-1:0] ramblock,
    output logic                  cfg_pending,
    output logic                  cfg_stb,
    output logic [3:0]            wr_count
);

    logic [1:0]            rst_sync_q;
    logic                  rst_n;
    logic                  cap;
    logic                  commit;

    logic [RAMBLOCK_W-1:0] pending_q, pending_d;
    logic                  pending_v_q, pending_v_d;
    logic [RAMBLOCK_W-1:0] ramblock_q, ramblock_d;
    logic                  stb_q, stb_d;
    logic [3:0]            wr_count_q, wr_count_d;

    // reset asserts immediately, releases only on a clock edge
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    cpc_iowr_qual #(
        .QUAL_SAMPLES (QUAL_SAMPLES)
    ) u_qual (
        .clk      (clk),
        .rst_n    (rst_n),
        .iorq_b   (iorq_b),
        .wr_b     (wr_b),
        .m1_b     (m1_b),
        .adr15    (adr15),
        .data_tag (data[7:6]),
        .cap      (cap)
    );

    // commit judged on the value already pending; a same-cycle capture only replaces it afterwards
    assign commit = pending_v_q & (mreq_b | ~APPLY_IDLE_ONLY);

    always_comb begin
        pending_d   = pending_q;
        pending_v_d = pending_v_q;
        ramblock_d  = ramblock_q;
        wr_count_d  = wr_count_q;
        stb_d       = commit;
        if (commit) begin
            ramblock_d  = pending_q;
            pending_v_d = 1'b0;
            wr_count_d  = wr_count_q + 4'd1;
        end
        if (cap) begin
            pending_d   = cfg_word(adr10, adr9, data[5:0]);
            pending_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            pending_v_q <= 1'b0;
            ramblock_q  <= '0;
            stb_q       <= 1'b0;
            wr_count_q  <= 4'd0;
        end else begin
            pending_q   <= pending_d;
            pending_v_q <= pending_v_d;
            ramblock_q  <= ramblock_d;
            stb_q       <= stb_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign ramblock    = ramblock_q;
    assign cfg_pending = pending_v_q;
    assign cfg_stb     = stb_q;
    assign wr_count    = wr_count_q;

endmodule
